div_iter: RTL and testbench
===========================

DIV_ITER -- requirements
Module: div_iter

Interface
REQ-001 The block SHALL have no parameters; the datapath is fixed at 32-bit operands and a 64-bit result.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  DIV/DIVU instruction in E stage requests a divide; held high by the E-stage stall until ready.
REQ-005 signed_div  input  1  1 = DIV (two's complement), 0 = DIVU.
REQ-006 opdata1  input  32  dividend (rs value after E-stage forwarding).
REQ-007 opdata2  input  32  divisor (rt value after E-stage forwarding).
REQ-008 annul  input  1  abort request from exception flush (flushE / flushM).
REQ-009 result  output  64  {remainder[63:32] -> HI, quotient[31:0] -> LO}.
REQ-010 ready  output  1  result valid; one-cycle pulse.
REQ-011 div_stall  output  1  stall request to the hazard unit; feeds stallF, stallD and stallE.

Function
REQ-012 The state machine SHALL have four states: IDLE, BYZERO, ON, END.
REQ-013 IDLE: on start=1 and annul=0, latch signed_div, opdata1 and opdata2; go to BYZERO if opdata2==0, otherwise go to ON.
REQ-014 Operands SHALL be latched only in IDLE; input changes during BYZERO, ON or END SHALL be ignored.
REQ-015 ON SHALL run radix-2 restoring division on magnitudes: one quotient bit per cycle, MSB first, using a 6-bit iteration counter and a 65-bit partial-remainder/quotient register.
REQ-016 Magnitudes SHALL come from two's-complement negation of negative operands when signed_div=1, and from the raw operands when signed_div=0.
REQ-017 After exactly 32 ON cycles the block SHALL go to END.
REQ-018 Signed fixup: quotient is negated if the dividend and divisor signs differ; remainder takes the sign of the dividend.
REQ-019 0x80000000 / 0xFFFFFFFF signed SHALL give quotient 0x80000000 and remainder 0, wrapping with no trap.
REQ-020 BYZERO SHALL last one cycle, then go to END with result = 64'h0.
REQ-021 END SHALL drive ready=1 for exactly one cycle, register the final result, and return to IDLE unconditionally.
REQ-022 result SHALL hold its value until the next END; it SHALL NOT be cleared by IDLE or by annul.
REQ-023 div_stall = start & ~ready & ~annul, combinational.
REQ-024 Latency, with start first seen in IDLE at cycle 0: div_stall is high in cycles 0..32 and ready=1 in cycle 33 (non-zero divisor); for a zero divisor, div_stall is high in cycles 0..1 and ready=1 in cycle 2.
REQ-025 annul=1 in BYZERO, ON or END SHALL force the next state to IDLE with ready=0 and result unchanged.
REQ-026 annul=1 in IDLE SHALL block the start.
REQ-027 annul has priority over start and over iteration completion.
REQ-028 start=1 in the cycle after END (back-to-back divide) SHALL begin a new operation from IDLE with freshly latched operands.
REQ-029 start dropping low in ON without annul SHALL NOT abort the operation; the divide completes and ready pulses.

Reset
REQ-030 resetn=0 SHALL immediately and asynchronously force: state=IDLE, counter=0, internal registers=0, result=64'h0, ready=0.
REQ-031 During reset, div_stall SHALL be 0 regardless of start.
REQ-032 The first rising clk edge after resetn rises SHALL be treated as IDLE.

Verification
REQ-033 DIVU 100/7 -> ready in cycle 33; result={32'd2, 32'd14}; div_stall high for exactly 33 cycles.
REQ-034 DIV 0xFFFFFFF9 / 2 -> result={32'hFFFFFFFF, 32'hFFFFFFFD}.
REQ-035 DIV 0x80000000 / 0xFFFFFFFF -> result={32'h0, 32'h80000000}.
REQ-036 DIVU 0x12345678 / 0 -> ready in cycle 2, result=64'h0.
REQ-037 annul pulsed in cycle 10 of ON -> IDLE next cycle, div_stall=0, no ready, result keeps its previous value; next DIVU 0xFFFFFFFF/16 -> {32'hF, 32'h0FFFFFFF}.
REQ-038 resetn low in cycle 5 of ON -> result=0 and ready=0 with no clock edge; after resetn rises, DIVU 9/3 -> {32'h0, 32'h3}.

Source files
------------

// File: rtl/div_iter.sv
// Iterative 32-bit signed/unsigned divider for the E stage: radix-2 restoring,
// one quotient bit per cycle, result = {remainder, quotient}.
module div_iter (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] opdata1,
  input  logic [31:0] opdata2,
  input  logic        annul,
  output logic [63:0] result,
  output logic        ready,
  output logic        div_stall
);

  localparam int unsigned W   = 32;
  localparam int unsigned CW  = 6;
  localparam int unsigned RQW = 2 * W + 1;

  typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [RQW-1:0]   rq_q, rq_d;
  logic [W-1:0]     dvs_q, dvs_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [2*W-1:0]   result_q, result_d;
  logic             ready_q, ready_d;

  logic [W-1:0]     mag1, mag2;
  logic [W+1:0]     prem;
  logic             ge;
  logic [W:0]       diff;
  logic [RQW-1:0]   step;
  logic [W-1:0]     quo_fix, rem_fix;

  // Operand magnitudes for the datapath
  always_comb begin
    mag1 = (signed_div && opdata1[W-1]) ? W'(32'd0 - opdata1) : opdata1;
    mag2 = (signed_div && opdata2[W-1]) ? W'(32'd0 - opdata2) : opdata2;
  end

  // One restoring step: shift partial remainder left, subtract divisor if it fits
  always_comb begin
    prem    = {rq_q[RQW-1:W], rq_q[W-1]};
    ge      = prem >= {2'b00, dvs_q};
    diff    = (W+1)'(prem - {2'b00, dvs_q});
    step    = ge ? {diff, rq_q[W-2:0], 1'b1} : {rq_q[RQW-2:0], 1'b0};
    quo_fix = qneg_q ? W'(32'd0 - step[W-1:0]) : step[W-1:0];
    rem_fix = rneg_q ? W'(32'd0 - step[2*W-1:W]) : step[2*W-1:W];
  end

  // Next-state and register updates
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rq_d     = rq_q;
    dvs_d    = dvs_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    ready_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !annul) begin
          cnt_d   = '0;
          rq_d    = {(W+1)'(0), mag1};
          dvs_d   = mag2;
          qneg_d  = signed_div & (opdata1[W-1] ^ opdata2[W-1]);
          rneg_d  = signed_div & opdata1[W-1];
          state_d = (opdata2 == '0) ? BYZERO : ON;
        end
      end
      BYZERO: begin
        if (annul) begin
          state_d = IDLE;
        end else begin
          state_d  = END;
          ready_d  = 1'b1;
          result_d = '0;
        end
      end
      ON: begin
        if (annul) begin
          state_d = IDLE;
        end else begin
          rq_d  = step;
          cnt_d = cnt_q + CW'(1);
          // Final result is captured on the edge into END so it is valid with ready
          if (cnt_q == CW'(W - 1)) begin
            state_d  = END;
            ready_d  = 1'b1;
            result_d = {rem_fix, quo_fix};
          end
        end
      end
      END: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rq_q     <= '0;
      dvs_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rq_q     <= rq_d;
      dvs_q    <= dvs_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result    = result_q;
  assign ready     = ready_q;
  assign div_stall = resetn & start & ~ready_q & ~annul;

endmodule

// File: tb/tb_div_iter.sv
// Directed self-checking bench for div_iter: latency, signed/unsigned results,
// divide-by-zero, annul, back-to-back and asynchronous reset.
module tb_div_iter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        annul;
  logic [63:0] result;
  logic        ready;
  logic        div_stall;

  int checks   = 0;
  int failures = 0;

  div_iter dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .signed_div (signed_div),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .annul      (annul),
    .result     (result),
    .ready      (ready),
    .div_stall  (div_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Launch one divide from IDLE (called just after a falling edge) and check it.
  task automatic do_div(input string tag, input logic sd, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int exp_cyc,
                        input bit drop, input bit b2b, input logic nsd,
                        input logic [31:0] na, input logic [31:0] nb);
    int          c;
    int          stalls;
    bit          got;
    logic [63:0] hold;
    signed_div = sd;
    opdata1    = a;
    opdata2    = b;
    annul      = 1'b0;
    start      = 1'b1;
    c = 0; stalls = 0; got = 1'b0;
    while (c < 60) begin
      #1;
      if (ready) begin
        got = 1'b1;
        break;
      end
      if (div_stall) stalls++;
      if (c == 3 && drop) start = 1'b0;
      if (c == 5) begin
        opdata1    = ~a;
        opdata2    = b ^ 32'h5;
        signed_div = ~sd;
      end
      @(negedge clk);
      c++;
    end
    chk({tag, ":ready_seen"}, 64'(got), 64'd1);
    chk({tag, ":ready_cycle"}, 64'(c), 64'(exp_cyc));
    chk({tag, ":result"}, result, exp);
    if (!drop) chk({tag, ":stall_cycles"}, 64'(stalls), 64'(exp_cyc));
    hold = result;
    if (b2b) begin
      signed_div = nsd;
      opdata1    = na;
      opdata2    = nb;
      start      = 1'b1;
    end else begin
      start = 1'b0;
    end
    @(negedge clk);
    #1;
    chk({tag, ":ready_pulse"}, 64'(ready), 64'd0);
    chk({tag, ":result_hold"}, result, hold);
  endtask

  initial begin
    logic [63:0] hold;
    bit          seen;

    resetn     = 1'b0;
    start      = 1'b1;
    signed_div = 1'b0;
    opdata1    = 32'd100;
    opdata2    = 32'd7;
    annul      = 1'b0;
    #12;
    chk("reset:result", result, 64'h0);
    chk("reset:ready", 64'(ready), 64'd0);
    chk("reset:stall", 64'(div_stall), 64'd0);
    @(negedge clk);
    start  = 1'b0;
    resetn = 1'b1;
    @(negedge clk);
    #1;

    do_div("divu_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    do_div("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, 1'b0,
           1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF);
    do_div("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 33, 1'b0,
           1'b0, 1'b0, 32'd0, 32'd0);
    do_div("divu_by0", 1'b0, 32'h12345678, 32'd0, 64'h0, 2, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    do_div("divu_m7_2", 1'b0, 32'hFFFFFFF9, 32'd2, {32'd1, 32'h7FFFFFFC}, 33, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    do_div("div_7_m2_drop", 1'b1, 32'd7, 32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD}, 33, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    do_div("divu_max_1", 1'b0, 32'hFFFFFFFF, 32'd1, {32'h0, 32'hFFFFFFFF}, 33, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    do_div("div_m100_m7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, {32'hFFFFFFFE, 32'd14}, 33, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    do_div("divu_5_9", 1'b0, 32'd5, 32'd9, {32'd5, 32'd0}, 33, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

    // Abort in the middle of ON
    hold       = result;
    signed_div = 1'b0;
    opdata1    = 32'd1000;
    opdata2    = 32'd3;
    start      = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    chk("annul_on:stall_before", 64'(div_stall), 64'd1);
    annul = 1'b1;
    #1;
    chk("annul_on:stall_during", 64'(div_stall), 64'd0);
    @(negedge clk);
    #1;
    chk("annul_on:ready", 64'(ready), 64'd0);
    chk("annul_on:result", result, hold);
    start = 1'b0;
    annul = 1'b0;
    #1;
    chk("annul_on:stall_idle", 64'(div_stall), 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (ready) seen = 1'b1;
    end
    chk("annul_on:no_ready", 64'(seen), 64'd0);

    // Abort held in IDLE blocks the start
    start = 1'b1;
    annul = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    annul = 1'b0;
    seen  = 1'b0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (ready) seen = 1'b1;
    end
    chk("annul_idle:no_ready", 64'(seen), 64'd0);
    chk("annul_idle:result", result, hold);

    do_div("divu_max_16", 1'b0, 32'hFFFFFFFF, 32'd16, {32'hF, 32'h0FFFFFFF}, 33, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

    // Asynchronous reset in the middle of ON
    signed_div = 1'b0;
    opdata1    = 32'd100;
    opdata2    = 32'd7;
    start      = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    resetn = 1'b0;
    #1;
    chk("async_rst:result", result, 64'h0);
    chk("async_rst:ready", 64'(ready), 64'd0);
    chk("async_rst:stall", 64'(div_stall), 64'd0);
    start = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    #1;
    do_div("divu_9_3", 1'b0, 32'd9, 32'd3, {32'h0, 32'h3}, 33, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
